// File: rtl/branch_target_gen.sv
// branch_target_gen: phase-scheduled branch target generator with a one-entry valid/ready output register
module branch_target_gen #(
  parameter int XLEN       = 32,
  parameter int PHASES     = 10,
  parameter int CALC_PHASE = 4,
  parameter int IMM_SHIFT  = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      stall,
  input  logic [XLEN-1:0]           pc_in,
  input  logic [XLEN-1:0]           imm_in,
  input  logic [XLEN-1:0]           rs1_in,
  input  logic [1:0]                mode,
  input  logic                      target_ready,
  output logic [XLEN-1:0]           target_out,
  output logic                      target_valid,
  output logic                      misaligned,
  output logic                      overrun,
  output logic [$clog2(PHASES)-1:0] phase_out
);
  localparam int CW = $clog2(PHASES);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [XLEN-1:0] simm, sum_pc, sum_rs1, result;
  logic calc, active, load, drop;
  assign simm    = imm_in << IMM_SHIFT;
  assign sum_pc  = pc_in + simm;
  assign sum_rs1 = rs1_in + simm;
  assign result  = mode == 2'b00 ? sum_pc : mode == 2'b01 ? {sum_rs1[XLEN-1:1], 1'b0} : pc_in + XLEN'(4);
  assign cnt_next = cnt == CW'(PHASES - 1) ? '0 : cnt + CW'(1);
  assign calc     = !stall && cnt_next == CW'(CALC_PHASE);
  assign active   = calc && mode != 2'b11;
  assign target_valid = state == FULL;
  assign phase_out    = cnt;
  // Control: a real compute event loads when the slot is free or being drained, else it is dropped;
  // an accepted result with no compute event on the same edge empties the slot
  always_comb begin
    load       = active && (state == EMPTY || target_ready);
    drop       = active && state == FULL && !target_ready;
    state_next = load ? FULL : (state == FULL && target_ready && !calc) ? EMPTY : state;
  end
  // State, phase counter, result register and sticky overrun flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= EMPTY;
      cnt        <= '0;
      target_out <= '0;
      misaligned <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state <= state_next;
      if (!stall) cnt <= cnt_next;
      if (load) begin
        target_out <= result;
        misaligned <= mode != 2'b10 && result[1:0] != 2'b00;
      end
      if (drop) overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_branch_target_gen.sv
// tb_branch_target_gen: directed-vector self-checking bench for branch_target_gen
module tb_branch_target_gen;
  logic        clock, reset, stall, target_ready, target_valid, misaligned, overrun;
  logic [31:0] pc_in, imm_in, rs1_in, target_out;
  logic [1:0]  mode;
  logic [3:0]  phase_out;
  int checks = 0;
  int errors = 0;

  branch_target_gen dut (
    .clock(clock), .reset(reset), .stall(stall), .pc_in(pc_in), .imm_in(imm_in),
    .rs1_in(rs1_in), .mode(mode), .target_ready(target_ready), .target_out(target_out),
    .target_valid(target_valid), .misaligned(misaligned), .overrun(overrun), .phase_out(phase_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic edges(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (target_out !== 32'h0) begin errors++; $display("FAIL reset_target got %h exp %h", target_out, 32'h0); end
    checks++; if ({target_valid, misaligned, overrun} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp %b", {target_valid, misaligned, overrun}, 3'b000); end
    checks++; if (phase_out !== 4'd0) begin errors++; $display("FAIL reset_phase got %0d exp %0d", phase_out, 0); end
    edges(1);
    checks++; if (phase_out !== 4'd1) begin errors++; $display("FAIL first_edge_phase got %0d exp %0d", phase_out, 1); end
  endtask

  task automatic test_pc_rel();
    mode = 2'b00; pc_in = 32'h100; imm_in = 32'd8; target_ready = 1'b1; stall = 1'b0;
    do_reset();
    edges(3);
    checks++; if (target_valid !== 1'b0 || phase_out !== 4'd3) begin errors++; $display("FAIL pcrel_edge3 got valid=%b phase=%0d exp valid=0 phase=3", target_valid, phase_out); end
    edges(1);
    checks++; if (target_out !== 32'h110) begin errors++; $display("FAIL pcrel_target got %h exp %h", target_out, 32'h110); end
    checks++; if ({target_valid, misaligned} !== 2'b10) begin errors++; $display("FAIL pcrel_flags got %b exp %b", {target_valid, misaligned}, 2'b10); end
    checks++; if (phase_out !== 4'd4) begin errors++; $display("FAIL pcrel_phase got %0d exp %0d", phase_out, 4); end
    edges(1);
    checks++; if (target_valid !== 1'b0 || target_out !== 32'h110) begin errors++; $display("FAIL pcrel_accept got valid=%b target=%h exp valid=0 target=00000110", target_valid, target_out); end
  endtask

  task automatic test_reg_rel();
    mode = 2'b01; rs1_in = 32'h203; imm_in = 32'd2; pc_in = 32'h0; target_ready = 1'b1; stall = 1'b0;
    do_reset();
    edges(4);
    checks++; if (target_out !== 32'h206) begin errors++; $display("FAIL regrel_target got %h exp %h", target_out, 32'h206); end
    checks++; if ({target_valid, misaligned} !== 2'b11) begin errors++; $display("FAIL regrel_flags got %b exp %b", {target_valid, misaligned}, 2'b11); end
  endtask

  task automatic test_wrap();
    mode = 2'b00; pc_in = 32'hFFFF_FFFC; imm_in = 32'd2; target_ready = 1'b1; stall = 1'b0;
    do_reset();
    edges(4);
    checks++; if (target_out !== 32'h0) begin errors++; $display("FAIL wrap_target got %h exp %h", target_out, 32'h0); end
    checks++; if ({target_valid, misaligned} !== 2'b10) begin errors++; $display("FAIL wrap_flags got %b exp %b", {target_valid, misaligned}, 2'b10); end
  endtask

  task automatic test_overrun();
    mode = 2'b00; pc_in = 32'h100; imm_in = 32'd8; target_ready = 1'b0; stall = 1'b0;
    do_reset();
    edges(4);
    checks++; if (target_out !== 32'h110 || target_valid !== 1'b1 || overrun !== 1'b0) begin errors++; $display("FAIL ovr_first got target=%h valid=%b ovr=%b exp 00000110 1 0", target_out, target_valid, overrun); end
    pc_in = 32'h200; imm_in = 32'd4;
    edges(9);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_edge13 got %b exp %b", overrun, 1'b0); end
    edges(1);
    checks++; if (target_out !== 32'h110 || target_valid !== 1'b1) begin errors++; $display("FAIL ovr_keep got target=%h valid=%b exp 00000110 1", target_out, target_valid); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %b exp %b", overrun, 1'b1); end
    target_ready = 1'b1;
    edges(2);
    checks++; if (target_valid !== 1'b0 || overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got valid=%b ovr=%b exp 0 1", target_valid, overrun); end
    do_reset();
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_reset got %b exp %b", overrun, 1'b0); end
  endtask

  task automatic test_stall();
    mode = 2'b10; pc_in = 32'h100; imm_in = 32'd0; target_ready = 1'b0; stall = 1'b0;
    do_reset();
    edges(3);
    stall = 1'b1;
    edges(3);
    checks++; if (phase_out !== 4'd3 || target_valid !== 1'b0) begin errors++; $display("FAIL stall_hold got phase=%0d valid=%b exp 3 0", phase_out, target_valid); end
    stall = 1'b0;
    edges(1);
    checks++; if (target_out !== 32'h104 || target_valid !== 1'b1 || misaligned !== 1'b0 || phase_out !== 4'd4) begin errors++; $display("FAIL stall_delay got target=%h valid=%b mis=%b phase=%0d exp 00000104 1 0 4", target_out, target_valid, misaligned, phase_out); end
    stall = 1'b1; target_ready = 1'b1;
    edges(1);
    checks++; if (target_valid !== 1'b0 || phase_out !== 4'd4) begin errors++; $display("FAIL stall_accept got valid=%b phase=%0d exp 0 4", target_valid, phase_out); end
    stall = 1'b0;
  endtask

  task automatic test_noop();
    mode = 2'b11; pc_in = 32'h300; imm_in = 32'd8; target_ready = 1'b0; stall = 1'b0;
    do_reset();
    edges(4);
    checks++; if (target_valid !== 1'b0 || target_out !== 32'h0) begin errors++; $display("FAIL noop_empty got valid=%b target=%h exp 0 00000000", target_valid, target_out); end
    mode = 2'b00;
    edges(10);
    mode = 2'b11; pc_in = 32'h500;
    edges(10);
    checks++; if (target_out !== 32'h310 || target_valid !== 1'b1 || overrun !== 1'b0) begin errors++; $display("FAIL noop_full got target=%h valid=%b ovr=%b exp 00000310 1 0", target_out, target_valid, overrun); end
  endtask

  task automatic test_async_reset();
    mode = 2'b01; rs1_in = 32'h203; imm_in = 32'd2; target_ready = 1'b0; stall = 1'b0;
    do_reset();
    edges(14);
    checks++; if (target_valid !== 1'b1 || misaligned !== 1'b1 || overrun !== 1'b1) begin errors++; $display("FAIL async_pre got valid=%b mis=%b ovr=%b exp 1 1 1", target_valid, misaligned, overrun); end
    #2 reset = 1'b1;
    #1;
    checks++; if (target_out !== 32'h0 || {target_valid, misaligned, overrun} !== 3'b000 || phase_out !== 4'd0) begin errors++; $display("FAIL async_reset got target=%h flags=%b phase=%0d exp 00000000 000 0", target_out, {target_valid, misaligned, overrun}, phase_out); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; pc_in = '0; imm_in = '0; rs1_in = '0; mode = 2'b00; target_ready = 1'b1;
    test_reset();
    test_pc_rel();
    test_reg_rel();
    test_wrap();
    test_overrun();
    test_stall();
    test_noop();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_target_gen.md
BRANCH_TARGET_GEN -- requirements
Module: branch_target_gen

Interface
REQ-001 SHALL have parameter XLEN, default 32: datapath width.
REQ-002 SHALL have parameter PHASES, default 10: phase-counter modulus, legal range 2..16.
REQ-003 SHALL have parameter CALC_PHASE, default 4: compute phase, legal range 0..PHASES-1.
REQ-004 SHALL have parameter IMM_SHIFT, default 1: left shift applied to the immediate, legal range 0..3.
REQ-005 SHALL have port clock, input, 1: clock; reset is reset, asynchronous, active-high.
REQ-006 SHALL have port reset, input, 1: asynchronous active-high reset.
REQ-007 SHALL have port stall, input, 1: freezes the phase counter and suppresses compute events.
REQ-008 SHALL have port pc_in, input, XLEN: current PC.
REQ-009 SHALL have port imm_in, input, XLEN: sign-extended immediate.
REQ-010 SHALL have port rs1_in, input, XLEN: register base for register-relative targets.
REQ-011 SHALL have port mode, input, 2: 00 PC-relative, 01 register-relative, 10 sequential, 11 no-op.
REQ-012 SHALL have port target_ready, input, 1: consumer accepts target_out.
REQ-013 SHALL have port target_out, output, XLEN: registered target.
REQ-014 SHALL have port target_valid, output, 1: target_out holds an unconsumed result.
REQ-015 SHALL have port misaligned, output, 1: target_out[1:0] is nonzero for mode 00 or 01.
REQ-016 SHALL have port overrun, output, 1: sticky flag, a compute event was dropped.
REQ-017 SHALL have port phase_out, output, clog2(PHASES): current counter value.

Function
REQ-018 Phase counter SHALL follow cnt_next = (cnt==PHASES-1) ? 0 : cnt+1 on every edge with stall=0, and SHALL hold on every edge with stall=1.
REQ-019 A compute event SHALL occur on an edge where stall=0 and cnt_next==CALC_PHASE.
REQ-020 The inputs SHALL be sampled at the compute edge, and the result SHALL be visible on target_out immediately after that edge (latency 1 edge).
REQ-021 The scaled immediate simm SHALL be imm_in shifted left by IMM_SHIFT, truncated to XLEN bits.
REQ-022 Mode 00 SHALL compute pc_in+simm; mode 01 SHALL compute (rs1_in+simm) with bit 0 cleared; mode 10 SHALL compute pc_in+4.
REQ-023 All sums SHALL wrap modulo 2^XLEN, with no carry-out flag.
REQ-024 Mode 11 compute events SHALL leave target_out, target_valid, misaligned and overrun unchanged.
REQ-025 misaligned SHALL be registered together with target_out; it SHALL be 0 for mode 10.
REQ-026 Handshake: target_valid SHALL clear on an edge with target_valid=1, target_ready=1 and no compute event.
REQ-027 A compute event with target_valid=0, or with target_valid=1 and target_ready=1, SHALL load the new result and set or keep target_valid=1.
REQ-028 A compute event with target_valid=1 and target_ready=0 SHALL discard the new result, keep target_out, and set overrun=1.
REQ-029 overrun SHALL clear only on reset.
REQ-030 stall SHALL NOT affect the handshake; target_valid SHALL clear on acceptance during a stall.
REQ-031 Control SHALL be a two-state FSM, EMPTY (valid=0) and FULL (valid=1), with transitions as defined in REQ-026 to REQ-028.

Reset
REQ-032 While reset=1, the block SHALL asynchronously force cnt=0, target_out=0, target_valid=0, misaligned=0, overrun=0 and FSM=EMPTY.
REQ-033 An in-flight result SHALL be lost on reset.
REQ-034 The first edge after reset release with stall=0 SHALL set cnt=1.

Verification
REQ-035 Bench SHALL cover: defaults, reset release, stall=0, mode 00, pc_in=0x100, imm_in=8 -> 4th edge gives target_out=0x110, valid=1, misaligned=0, phase_out=4.
REQ-036 Bench SHALL cover: mode 01, rs1_in=0x203, imm_in=2 -> target_out=0x206, misaligned=1.
REQ-037 Bench SHALL cover: mode 00, pc_in=0xFFFFFFFC, imm_in=2 -> target_out=0x00000000 (wrap).
REQ-038 Bench SHALL cover: target_ready=0 through compute events at edges 4 and 14, with inputs changed between them -> target_out keeps the first result, overrun=1 from edge 14 until reset.
REQ-039 Bench SHALL cover: stall=1 for 3 edges while cnt=3 -> compute event delayed to edge 7, and phase_out stays 3 during the stall.
REQ-040 Bench SHALL cover: reset asserted mid-cycle while valid=1 -> all outputs go to 0 without waiting for a clock edge.
